// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// It sequences each frame from the transmitter's tx line and tx_done, and reports
// completion or timeout back to the requester that owns the transfer.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 4096,
    parameter int unsigned FRAME_TIMEOUT = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 send,
    output logic [7:0]           tx_data,
    input  logic                 tx_line,
    input  logic                 tx_done
);

    localparam int unsigned MaxTo = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT
                                                                     : FRAME_TIMEOUT;
    localparam int unsigned TW    = $clog2(MaxTo) + 1;
    localparam int unsigned PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [TW-1:0] StartLast = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] FrameLast = TW'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StBusy, StDrain} state_e;

    state_e               state_q, state_d;
    logic                 send_q, send_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [TW-1:0]        timer_q, timer_d;

    logic                 tx_m_q, tx_s_q, tx_p_q;
    logic                 done_m_q, done_s_q, done_p_q;
    logic                 start_evt, fin_evt;

    logic                 win_found;
    logic [PW-1:0]        win_idx;
    logic [7:0]           win_byte;
    logic [TW-1:0]        timer_inc;

    // Modular increment of a requester index.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                               input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Two-flop synchronizers plus one edge-detect register per transmitter signal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_m_q   <= 1'b1;
            tx_s_q   <= 1'b1;
            tx_p_q   <= 1'b1;
            done_m_q <= 1'b0;
            done_s_q <= 1'b0;
            done_p_q <= 1'b0;
        end else begin
            tx_m_q   <= tx_line;
            tx_s_q   <= tx_m_q;
            tx_p_q   <= tx_s_q;
            done_m_q <= tx_done;
            done_s_q <= done_m_q;
            done_p_q <= done_s_q;
        end
    end

    assign start_evt = tx_p_q & ~tx_s_q;
    assign fin_evt   = done_s_q & ~done_p_q;
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);

    // Pick the first pending requester at or after ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_byte  = 8'h00;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[wrap_add(ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(ptr_q, k);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PW'(i) == win_idx) win_byte = req_data[8*i +: 8];
        end
    end

    // State register and the registered outputs that go with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            send_q    <= 1'b0;
            tx_data_q <= 8'h00;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            send_q    <= send_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
        end
    end

    // Next-state logic: grant, frame sequencing and timeout supervision.
    always_comb begin
        state_d   = state_q;
        send_d    = send_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d   = NUM_REQ'(1) << win_idx;
                    tx_data_d = win_byte;
                    send_d    = 1'b1;
                    timer_d   = '0;
                    ptr_d     = wrap_add(win_idx, 1);
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (start_evt) begin
                    send_d  = 1'b0;
                    timer_d = '0;
                    state_d = StBusy;
                end else if (timer_q >= StartLast) begin
                    send_d  = 1'b0;
                    err_d   = grant_q;
                    grant_d = '0;
                    state_d = StDrain;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StBusy: begin
                if (fin_evt) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = StDrain;
                end else if (timer_q >= FrameLast) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    state_d = StDrain;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StDrain: begin
                // Wait for an idle line and low tx_done so the next frame sees clean edges.
                if (!done_s_q && tx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic.
    always_comb begin
        busy    = (state_q != StIdle);
        send    = send_q;
        tx_data = tx_data_q;
        grant   = grant_q;
        done    = done_q;
        err     = err_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter; the bench itself plays the transmitter.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   done, err, grant;
    logic            busy, send;
    logic [7:0]      tx_data;
    logic            tx_line = 1'b1;
    logic            tx_done = 1'b0;

    int checks = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .START_TIMEOUT(16),
        .FRAME_TIMEOUT(64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .done    (done),
        .err     (err),
        .grant   (grant),
        .busy    (busy),
        .send    (send),
        .tx_data (tx_data),
        .tx_line (tx_line),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve one frame: expect grant to idx with byte_v, send bits, raise tx_done.
    task automatic transact(input int idx, input logic [7:0] byte_v,
                            input logic [NR-1:0] drop_mask);
        int n;
        int cnt;
        n = 0;
        while (!send && n < 20) begin step(); n++; end
        chk("send_seen", 32'(send), 32'd1);
        chk("grant", 32'(grant), 32'(4'b0001 << idx));
        chk("tx_data", 32'(tx_data), 32'(byte_v));
        chk("busy_send", 32'(busy), 32'd1);
        tx_line = 1'b0;
        cnt = 0;
        n = 0;
        while (send && n < 20) begin step(); if (send) cnt++; n++; end
        chk("send_len", cnt, 2);
        chk("busy_frame", 32'(busy), 32'd1);
        step();
        for (int b = 0; b < 8; b++) begin
            tx_line = byte_v[b];
            repeat (4) step();
        end
        tx_line = 1'b1;
        repeat (4) step();
        tx_done = 1'b1;
        n = 0;
        while (done == '0 && n < 20) begin step(); n++; end
        chk("done", 32'(done), 32'(4'b0001 << idx));
        chk("err_none", 32'(err), 32'd0);
        chk("grant_clear", 32'(grant), 32'd0);
        req = req & ~drop_mask;
        step();
        chk("done_width", 32'(done), 32'd0);
        tx_done = 1'b0;
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        chk("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int cnt;

        // Reset values.
        repeat (2) step();
        chk("rst_send", 32'(send), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        rst = 1'b1;
        step();

        // Single requester, byte 0xA5.
        req_data = 32'h44A5_2211;
        req = 4'b0100;
        transact(2, 8'hA5, 4'b0100);

        // Fresh pointer, then all four at once.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        req_data = 32'h4433_2211;
        req = 4'b1111;
        transact(0, 8'h11, 4'b0001);
        transact(1, 8'h22, 4'b0010);
        transact(2, 8'h33, 4'b0100);
        transact(3, 8'h44, 4'b1000);

        // Fairness: req[0] keeps asking while req[3] stays pending.
        req = 4'b1001;
        transact(0, 8'h11, 4'b0000);
        transact(3, 8'h44, 4'b0000);
        transact(0, 8'h11, 4'b0000);
        transact(3, 8'h44, 4'b1001);

        // Start timeout: line never falls.
        req = 4'b0010;
        n = 0;
        while (!send && n < 20) begin step(); n++; end
        chk("sto_send", 32'(send), 32'd1);
        cnt = 1;
        n = 0;
        while (send && n < 100) begin step(); if (send) cnt++; n++; end
        chk("sto_len", cnt, 16);
        chk("sto_err", 32'(err), 32'b0010);
        chk("sto_done", 32'(done), 32'd0);
        req = '0;
        step();
        chk("sto_err_width", 32'(err), 32'd0);
        chk("sto_idle", 32'(busy), 32'd0);

        // Frame timeout: start bit seen but tx_done never rises.
        req = 4'b0100;
        n = 0;
        while (!send && n < 20) begin step(); n++; end
        chk("fto_grant", 32'(grant), 32'b0100);
        tx_line = 1'b0;
        n = 0;
        while (send && n < 20) begin step(); n++; end
        tx_line = 1'b1;
        cnt = 0;
        n = 0;
        while (err == '0 && n < 200) begin step(); cnt++; n++; end
        chk("fto_len", cnt, 64);
        chk("fto_err", 32'(err), 32'b0100);
        chk("fto_done", 32'(done), 32'd0);
        req = '0;
        step();
        chk("fto_err_width", 32'(err), 32'd0);
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        chk("fto_idle", 32'(busy), 32'd0);
        req = 4'b0001;
        transact(0, 8'h11, 4'b0001);

        // Reset in the middle of a frame.
        req = 4'b1000;
        n = 0;
        while (!send && n < 20) begin step(); n++; end
        tx_line = 1'b0;
        repeat (6) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out", 32'({send, grant, busy, done, err}), 32'd0);
        chk("mid_rst_data", 32'(tx_data), 32'd0);
        req = '0;
        tx_line = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();
        req = 4'b0010;
        transact(1, 8'h22, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares one `uarttx` transmitter among `NUM_REQ` byte producers. It sits between the requesters and the transmitter and drives the transmitter's `send`/`tx_data`. It observes the transmitter's `tx` line and `tx_done` to sequence each frame. It also reports per-requester completion or timeout, so no producer ever talks to the transmitter directly.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `START_TIMEOUT`, 4096, max `clk` cycles from `send` assertion to detected start bit
- `FRAME_TIMEOUT`, 65536, max `clk` cycles from start bit to detected `tx_done` rise
- `clk`  in  1  system clock (same clock that feeds `uarttx`)
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  NUM_REQ  per-requester request level
- `req_data`  in  8*NUM_REQ  byte of requester i at `[8*i+7:8*i]`
- `done`  out  NUM_REQ  one-cycle pulse: requester i's byte fully sent
- `err`  out  NUM_REQ  one-cycle pulse: requester i's transfer aborted on timeout
- `grant`  out  NUM_REQ  one-hot, owner of the current transfer
- `busy`  out  1  high whenever state ≠ IDLE
- `send`  out  1  to `uarttx.send`
- `tx_data`  out  8  to `uarttx.tx_data`
- `tx_line`  in  1  from `uarttx.tx`
- `tx_done`  in  1  from `uarttx.tx_done`

## Operation
- `tx_line` and `tx_done` come from the transmitter's baud-clock domain. Each passes through a 2-flop synchronizer in `clk`, producing `tx_s` and `done_s`. The synchronizer flops reset to `tx_s`=1 and `done_s`=0.
- Edge detection uses one extra register on each signal:
  - `start_evt` is `tx_s` falling.
  - `fin_evt` is `done_s` rising.
- Round-robin pointer `ptr` (0..NUM_REQ-1) resets to 0.
  - The winner is the first i with `req[i]`=1, scanning from `ptr` upward with wrap.
  - On grant to i, `ptr` becomes (i+1) mod NUM_REQ, whether the transfer later ends in `done` or `err`.
- Requester contract:
  - Hold `req[i]` and its byte stable until the `done[i]` or `err[i]` pulse.
  - `req[i]` still high in the cycle after the pulse counts as a new request.
  - Byte changes after grant are ignored, because the byte is latched at grant.
- FSM states and transitions:
  - IDLE: when any `req` is high, latch the winner into `grant` and its byte into `tx_data`, set `send`=1, clear the timer, go to SEND. Otherwise stay.
  - SEND: on `start_evt`, set `send`=0, clear the timer, go to BUSY. If the timer reaches `START_TIMEOUT`, set `send`=0, pulse `err[grant]`, go to DRAIN.
  - BUSY: on `fin_evt`, pulse `done[grant]`, go to DRAIN. If the timer reaches `FRAME_TIMEOUT`, pulse `err[grant]`, go to DRAIN.
  - DRAIN: `grant` is cleared on entry. When `done_s`=0 and `tx_s`=1, go to IDLE. This guarantees a clean edge for the next frame.
- `send` is dropped as soon as the start bit is seen. This stops `uarttx` from re-launching the same byte when it returns to idle.
- `req` deasserting mid-transfer does not abort the frame; completion is still pulsed.
- The timer is a saturating counter of width clog2(max(START_TIMEOUT, FRAME_TIMEOUT))+1.

## Timing
- Reset values (async assert, synchronous release): `send`=0, `tx_data`=0, `grant`=0, `done`=0, `err`=0, `busy`=0, state IDLE, `ptr`=0.
- Reset asserted mid-frame returns everything to reset values immediately. The transmitter frame in flight is not stopped by this block.
- Request to `send`: `req` high in cycle N gives `send`, `grant`, `tx_data` and `busy` valid in cycle N+1.
- Start-bit detect latency is 3 `clk` cycles after the `tx_line` fall (2 synchronizer flops + 1 edge register). `send` falls in the same cycle the FSM enters BUSY.
- `done`/`err` are exactly 1 cycle wide and mutually exclusive, with at most one bit set.
- A new grant needs at least one IDLE cycle after DRAIN. Back-to-back requests therefore see `send` re-asserted no earlier than 2 cycles after DRAIN exits.
- Simultaneous requests are resolved purely by `ptr`. No requester is granted twice while another requester stays continuously pending.

## Test plan
- Single requester: `req[2]`=1 with byte 0xA5, using a `uarttx` model at clk_freq=1e6, baud 9600. Required: `send` for ≤4 cycles after the start bit, serial bits 1,0,1,0,0,1,0,1 (LSB first), one `done[2]` pulse, `grant` returns to 0, `busy` low afterwards.
- Simultaneous `req`=4'b1111 with bytes 0x11/0x22/0x33/0x44, held until each done. Required: frames sent in order 0,1,2,3, and `ptr` is back to 0.
- Fairness: `req[0]` re-requests immediately after each done while `req[3]` is pending. Required: grants alternate 0,3,0,3.
- Start timeout: `tx_line` tied high and START_TIMEOUT=16. Required: `send` drops after 16 cycles in SEND, a single `err[i]` pulse, no `done`, return to IDLE.
- Frame timeout: `tx_line` pulses low but `tx_done` is never raised, FRAME_TIMEOUT=64. Required: `err[i]` after 64 cycles in BUSY, and the next request is served normally.
- Reset mid-BUSY: `rst`=0 for 2 cycles. Required: all outputs 0 asynchronously, `ptr`=0, and a subsequent request from `req[1]` completes correctly.
